// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deserializer
// Purpose  : UART receive path. Oversamples RX_IN, detects the start bit,
//            takes a 2-of-3 majority vote around the middle of each bit,
//            shifts in DATA_WIDTH bits LSB first, checks the optional parity
//            bit and the stop bit, and reports the result with one-cycle
//            pulses.
// Ports    : CLK           system clock
//            RST           asynchronous active-low reset
//            RX_IN         serial line, idles high, already synchronised
//            Prescale      oversampling ratio (8, 16 or 32)
//            PAR_EN        1 = parity bit follows the data bits
//            PAR_TYP       0 = even, 1 = odd parity
//            P_DATA        last correctly received byte
//            Data_Valid    one-cycle pulse on a good frame
//            parity_error  one-cycle pulse on a bad parity bit
//            framing_error one-cycle pulse on a stop bit sampled as 0
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  parity_error,
    output logic                  framing_error
);

    localparam int                 c_BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    logic [2:0]            r_state;
    logic [5:0]            r_edge_cnt;
    logic [c_BIT_W-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [2:0]            r_samples;
    logic [5:0]            r_prescale;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_par_err;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_data_valid;
    logic                  r_parity_error;
    logic                  r_framing_error;

    logic [5:0] w_half;
    logic [5:0] w_samp_lo;
    logic [5:0] w_samp_hi;
    logic       w_last_edge;
    logic       w_bit;
    logic       w_exp_par;

    // Sample points sit symmetrically around the middle of the bit window.
    assign w_half      = {1'b0, r_prescale[5:1]};
    assign w_samp_lo   = w_half - 6'd1;
    assign w_samp_hi   = w_half + 6'd1;
    assign w_last_edge = (r_edge_cnt == (r_prescale - 6'd1));

    // 2-of-3 majority; rejects a single-cycle glitch on any one sample.
    assign w_bit = (r_samples[0] & r_samples[1]) |
                   (r_samples[0] & r_samples[2]) |
                   (r_samples[1] & r_samples[2]);

    // Even parity expects XOR(data); odd parity expects its complement.
    assign w_exp_par = (^r_shift) ^ r_par_typ;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state         <= c_ST_IDLE;
            r_edge_cnt      <= '0;
            r_bit_cnt       <= '0;
            r_shift         <= '0;
            r_samples       <= '0;
            r_prescale      <= '0;
            r_par_en        <= 1'b0;
            r_par_typ       <= 1'b0;
            r_par_err       <= 1'b0;
            r_p_data        <= '0;
            r_data_valid    <= 1'b0;
            r_parity_error  <= 1'b0;
            r_framing_error <= 1'b0;
        end else begin
            r_data_valid    <= 1'b0;
            r_parity_error  <= 1'b0;
            r_framing_error <= 1'b0;

            if (r_state != c_ST_IDLE) begin
                if (r_edge_cnt == w_samp_lo) r_samples[0] <= RX_IN;
                if (r_edge_cnt == w_half)    r_samples[1] <= RX_IN;
                if (r_edge_cnt == w_samp_hi) r_samples[2] <= RX_IN;
                if (w_last_edge) begin
                    r_edge_cnt <= '0;
                end else begin
                    r_edge_cnt <= r_edge_cnt + 6'd1;
                end
            end

            case (r_state)
                c_ST_IDLE: begin
                    // The detecting cycle is edge 0 of the start bit, so the
                    // counter resumes at 1 on the following cycle.
                    if (!RX_IN) begin
                        r_state    <= c_ST_START;
                        r_edge_cnt <= 6'd1;
                        r_bit_cnt  <= '0;
                        r_par_err  <= 1'b0;
                        r_prescale <= Prescale;
                        r_par_en   <= PAR_EN;
                        r_par_typ  <= PAR_TYP;
                    end
                end
                c_ST_START: begin
                    if (w_last_edge) begin
                        r_state <= w_bit ? c_ST_IDLE : c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (w_last_edge) begin
                        r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? c_ST_PARITY : c_ST_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                c_ST_PARITY: begin
                    if (w_last_edge) begin
                        r_par_err <= (w_bit != w_exp_par);
                        r_state   <= c_ST_STOP;
                    end
                end
                c_ST_STOP: begin
                    if (w_last_edge) begin
                        r_state         <= c_ST_IDLE;
                        r_framing_error <= ~w_bit;
                        r_parity_error  <= r_par_err;
                        if (w_bit && !r_par_err) begin
                            r_p_data     <= r_shift;
                            r_data_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign P_DATA        = r_p_data;
    assign Data_Valid    = r_data_valid;
    assign parity_error  = r_parity_error;
    assign framing_error = r_framing_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_deserializer
// Purpose  : Self-checking bench for uart_rx_deserializer. Each frame sent
//            pushes its expected outcome (flags, pulse cycle, P_DATA) into a
//            scoreboard; a monitor pops and compares on every output pulse.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_deserializer;

    typedef struct {
        logic [7:0] data;
        logic       dv;
        logic       pe;
        logic       fe;
        int         cyc;
    } exp_t;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rx       = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       par_en   = 1'b0;
    logic       par_typ  = 1'b0;
    logic [7:0] p_data;
    logic       dv;
    logic       pe;
    logic       fe;

    int         tests     = 0;
    int         fails     = 0;
    int         cyc       = 0;
    logic [7:0] last_good = 8'h00;
    exp_t       sb[$];

    uart_rx_deserializer #(.DATA_WIDTH(8)) dut (
        .CLK          (clk),
        .RST          (rst_n),
        .RX_IN        (rx),
        .Prescale     (prescale),
        .PAR_EN       (par_en),
        .PAR_TYP      (par_typ),
        .P_DATA       (p_data),
        .Data_Valid   (dv),
        .parity_error (pe),
        .framing_error(fe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard consumer: every output pulse must match the oldest expectation.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (dv || pe || fe)) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_pulse: dv=%0b pe=%0b fe=%0b at cycle %0d, required no pulse",
                             dv, pe, fe, cyc);
                end else begin
                    e = sb.pop_front();
                    tests++;
                    if ({dv, pe, fe} !== {e.dv, e.pe, e.fe}) begin
                        fails++;
                        $display("FAIL pulse_flags: dv/pe/fe=%b%b%b, required %b%b%b", dv, pe, fe, e.dv, e.pe, e.fe);
                    end
                    tests++;
                    if (cyc !== e.cyc) begin
                        fails++;
                        $display("FAIL pulse_cycle: pulse at cycle %0d, required %0d", cyc, e.cyc);
                    end
                    tests++;
                    if (p_data !== e.data) begin
                        fails++;
                        $display("FAIL p_data_at_pulse: P_DATA=%h, required %h", p_data, e.data);
                    end
                end
            end
        end
    endtask

    task automatic drive_cycle(input logic v);
        @(posedge clk);
        #1 rx = v;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle(1'b1);
    endtask

    // Sends one frame; glitch_bit (frame bit index, -1 = none) flips the
    // line for the single cycle at the middle sample point of that bit.
    task automatic send_frame(input logic [7:0] d, input logic par_bit,
                              input logic stop_bit, input int glitch_bit);
        logic q[$];
        exp_t e;
        logic v;
        int   p;
        p = int'(prescale);
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (par_en) q.push_back(par_bit);
        q.push_back(stop_bit);
        e.pe = par_en && (par_bit !== ((^d) ^ par_typ));
        e.fe = !stop_bit;
        e.dv = !e.pe && !e.fe;
        if (e.dv) last_good = d;
        e.data = last_good;
        e.cyc  = 0;
        for (int b = 0; b < q.size(); b++) begin
            for (int k = 0; k < p; k++) begin
                v = q[b];
                if (b == glitch_bit && k == p / 2) v = ~v;
                drive_cycle(v);
                if (b == 0 && k == 0) begin
                    e.cyc = cyc + p * q.size();
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL missing_pulse: %0d expected pulses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({p_data, dv, pe, fe} !== 11'd0) begin
            fails++;
            $display("FAIL reset_outputs: P_DATA=%h dv=%b pe=%b fe=%b, required all 0", p_data, dv, pe, fe);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(4);
        tests++;
        if ({p_data, dv, pe, fe} !== 11'd0) begin
            fails++;
            $display("FAIL post_reset_idle: P_DATA=%h dv=%b pe=%b fe=%b, required all 0", p_data, dv, pe, fe);
        end
    endtask

    task automatic test_no_parity();
        prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b1, -1);
        idle(4);
        drain();
        tests++;
        if (p_data !== 8'hA5) begin
            fails++;
            $display("FAIL no_parity_data: P_DATA=%h, required a5", p_data);
        end
    endtask

    task automatic test_even_parity();
        prescale = 6'd16; par_en = 1'b1; par_typ = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b1, -1);
        idle(4);
        drain();
        tests++;
        if (p_data !== 8'h3C) begin
            fails++;
            $display("FAIL even_parity_data: P_DATA=%h, required 3c", p_data);
        end
    endtask

    task automatic test_parity_error();
        prescale = 6'd16; par_en = 1'b1; par_typ = 1'b1;
        send_frame(8'h12, 1'b1, 1'b1, -1);
        idle(3);
        send_frame(8'h3C, 1'b0, 1'b1, -1);
        idle(4);
        drain();
        tests++;
        if (p_data !== 8'h12) begin
            fails++;
            $display("FAIL parity_error_hold: P_DATA=%h, required 12", p_data);
        end
    endtask

    task automatic test_framing();
        prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
        send_frame(8'h81, 1'b0, 1'b0, -1);
        idle(4);
        drain();
        tests++;
        if (p_data !== 8'h12) begin
            fails++;
            $display("FAIL framing_hold: P_DATA=%h, required 12", p_data);
        end
        send_frame(8'h81, 1'b0, 1'b1, -1);
        idle(4);
        drain();
        tests++;
        if (p_data !== 8'h81) begin
            fails++;
            $display("FAIL framing_recover: P_DATA=%h, required 81", p_data);
        end
    endtask

    // Two low cycles are rejected; a real start bit at cycle 8 must be caught.
    task automatic test_start_glitch();
        prescale = 6'd8; par_en = 1'b0;
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        repeat (6) drive_cycle(1'b1);
        send_frame(8'h5A, 1'b0, 1'b1, -1);
        idle(4);
        drain();
        tests++;
        if (p_data !== 8'h5A) begin
            fails++;
            $display("FAIL start_glitch_next: P_DATA=%h, required 5a", p_data);
        end
    endtask

    task automatic test_data_glitch();
        prescale = 6'd16; par_en = 1'b0;
        send_frame(8'hC3, 1'b0, 1'b1, 4);
        idle(4);
        drain();
        tests++;
        if (p_data !== 8'hC3) begin
            fails++;
            $display("FAIL data_glitch: P_DATA=%h, required c3", p_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        prescale = 6'd8; par_en = 1'b0;
        repeat (8) drive_cycle(1'b0);
        repeat (8) drive_cycle(1'b1);
        repeat (4) drive_cycle(1'b0);
        #1 rst_n = 1'b0;
        rx = 1'b1;
        #1;
        tests++;
        if ({p_data, dv, pe, fe} !== 11'd0) begin
            fails++;
            $display("FAIL mid_frame_reset: P_DATA=%h dv=%b pe=%b fe=%b, required all 0", p_data, dv, pe, fe);
        end
        last_good = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(100);
        tests++;
        if ({p_data, dv, pe, fe} !== 11'd0) begin
            fails++;
            $display("FAIL partial_frame_silent: P_DATA=%h dv=%b pe=%b fe=%b, required all 0", p_data, dv, pe, fe);
        end
        send_frame(8'h96, 1'b0, 1'b1, -1);
        idle(4);
        drain();
        tests++;
        if (p_data !== 8'h96) begin
            fails++;
            $display("FAIL after_reset_frame: P_DATA=%h, required 96", p_data);
        end
    endtask

    task automatic test_back_to_back();
        prescale = 6'd32; par_en = 1'b0;
        send_frame(8'h55, 1'b0, 1'b1, -1);
        tests++;
        if (sb.size() != 1) begin
            fails++;
            $display("FAIL b2b_first_pending: %0d entries, required 1", sb.size());
        end
        send_frame(8'hAA, 1'b0, 1'b1, -1);
        idle(4);
        drain();
        tests++;
        if (p_data !== 8'hAA) begin
            fails++;
            $display("FAIL b2b_second_data: P_DATA=%h, required aa", p_data);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_no_parity();
        test_even_parity();
        test_parity_error();
        test_framing();
        test_start_glitch();
        test_data_glitch();
        test_reset_mid_frame();
        test_back_to_back();
        idle(10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
